// File: rtl/piho_result_reader.sv
// Read-side companion to the 8-unit harmonic-oscillator top: waits for finish,
// lets the x2sumall tree settle, snapshots the results and streams them as a checksummed byte packet.
module piho_result_reader #(
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter logic [7:0]  HDR0          = 8'hA5,
   parameter logic [7:0]  HDR1          = 8'h5A
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         finish,
   input  logic [511:0] x2sum_flat,
   input  logic [63:0]  x2sumall,
   input  logic [31:0]  looptimes,
   input  logic         rearm,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   input  logic         tx_ready,
   output logic         busy,
   output logic         done,
   output logic [15:0]  pkt_count
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SETTLE  = 3'd1;
   localparam logic [2:0] ST_CAPTURE = 3'd2;
   localparam logic [2:0] ST_SEND    = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [6:0] IDX_HDR0    = 7'd0;
   localparam logic [6:0] IDX_PAY_LO  = 7'd2;
   localparam logic [6:0] IDX_PAY_HI  = 7'd77;
   localparam logic [6:0] IDX_CHK     = 7'd78;

   logic [2:0]   state;
   logic         finish_d;
   logic         fin_rise;
   logic [7:0]   settle_cnt;
   logic [6:0]   byte_idx;
   logic [7:0]   chk;
   logic [7:0]   chk_upd;
   logic [607:0] shadow;
   logic         xfer;

   assign fin_rise = finish & ~finish_d;

   // Handshake: a byte moves on every cycle where tx_valid & tx_ready; while
   // tx_valid is high and tx_ready low, tx_data and tx_valid are held unchanged.
   assign xfer = tx_valid & tx_ready;

   assign busy = (state == ST_SETTLE) || (state == ST_CAPTURE) || (state == ST_SEND);
   assign done = (state == ST_DONE);

   // Checksum covers payload bytes only; headers and the checksum itself are excluded.
   always_comb begin
      chk_upd = chk;
      if (byte_idx >= IDX_PAY_LO && byte_idx <= IDX_PAY_HI) begin
         chk_upd = chk ^ tx_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         finish_d   <= 1'b0;
         settle_cnt <= 8'd0;
         byte_idx   <= 7'd0;
         chk        <= 8'd0;
         shadow     <= '0;
         tx_data    <= 8'd0;
         tx_valid   <= 1'b0;
         pkt_count  <= 16'd0;
      end else begin
         finish_d <= finish;
         case (state)
            ST_IDLE: begin
               if (fin_rise) begin
                  state      <= ST_SETTLE;
                  settle_cnt <= 8'd0;
               end
            end

            ST_SETTLE: begin
               settle_cnt <= settle_cnt + 8'd1;
               if (!finish) begin
                  state <= ST_IDLE;
               end else if (settle_cnt == SETTLE_LAST) begin
                  state <= ST_CAPTURE;
               end
            end

            ST_CAPTURE: begin
               // Payload is kept as one little-endian shift register: byte 2 sits in [7:0].
               shadow   <= {looptimes, x2sumall, x2sum_flat};
               byte_idx <= IDX_HDR0;
               chk      <= 8'd0;
               tx_data  <= HDR0;
               tx_valid <= 1'b1;
               state    <= ST_SEND;
            end

            ST_SEND: begin
               if (xfer) begin
                  byte_idx <= byte_idx + 7'd1;
                  chk      <= chk_upd;
                  if (byte_idx == IDX_CHK) begin
                     tx_valid  <= 1'b0;
                     tx_data   <= 8'd0;
                     pkt_count <= pkt_count + 16'd1;
                     state     <= ST_DONE;
                  end else if (byte_idx == IDX_PAY_HI) begin
                     tx_data <= chk_upd;
                  end else if (byte_idx == IDX_HDR0) begin
                     tx_data <= HDR1;
                  end else begin
                     tx_data <= shadow[7:0];
                     shadow  <= shadow >> 8;
                  end
               end
            end

            ST_DONE: begin
               if (rearm) begin
                  state <= ST_IDLE;
               end
            end

            default: begin
               state    <= ST_IDLE;
               tx_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piho_result_reader.sv
// Randomized bench for piho_result_reader: packet bytes are predicted from a
// byte-level model of the frame format and checked through an expected queue.
`timescale 1ns/1ps
module tb_piho_result_reader;

   localparam int S1 = 8;
   localparam int S2 = 2;

   logic         clk = 1'b0;
   logic         rst, finish, finish2, rearm, tx_ready, ready2;
   logic [511:0] x2sum_flat;
   logic [63:0]  x2sumall;
   logic [31:0]  looptimes;
   logic [7:0]   tx_data, tx_data2;
   logic         tx_valid, tx_valid2, busy, busy2, done, done2;
   logic [15:0]  pkt_count, pkt_count2;

   int tests_run = 0;
   int tests_failed = 0;

   logic [7:0]  exp_q[$];
   logic [7:0]  exp2_q[$];
   logic [63:0] m_x2[8];
   logic [63:0] m_all;
   logic [31:0] m_loop;

   bit         rand_ready = 1'b0;
   int         cyc = 0;
   int         n_bytes = 0;
   int         n_bytes2 = 0;
   int         first_cyc = 0;
   int         last_cyc = 0;
   logic [7:0] last_byte = 8'd0;
   bit         any_valid = 1'b0;
   bit         hold_pending = 1'b0;
   logic [7:0] hold_data = 8'd0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   piho_result_reader #(.SETTLE_CYCLES(S1)) dut (
      .clk(clk), .rst(rst), .finish(finish), .x2sum_flat(x2sum_flat),
      .x2sumall(x2sumall), .looptimes(looptimes), .rearm(rearm),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .done(done), .pkt_count(pkt_count)
   );

   piho_result_reader #(.SETTLE_CYCLES(S2)) dut2 (
      .clk(clk), .rst(rst), .finish(finish2), .x2sum_flat(x2sum_flat),
      .x2sumall(x2sumall), .looptimes(looptimes), .rearm(rearm),
      .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(ready2),
      .busy(busy2), .done(done2), .pkt_count(pkt_count2)
   );

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Reference frame: header, eight LE 64-bit units, LE total, LE loop count, XOR of payload.
   task automatic build_packet(input bit second);
      logic [7:0] b[$];
      logic [7:0] c;
      b.push_back(8'hA5);
      b.push_back(8'h5A);
      for (int u = 0; u < 8; u++)
         for (int k = 0; k < 8; k++) b.push_back(8'(m_x2[u] >> (8 * k)));
      for (int k = 0; k < 8; k++) b.push_back(8'(m_all >> (8 * k)));
      for (int k = 0; k < 4; k++) b.push_back(8'(m_loop >> (8 * k)));
      c = 8'd0;
      for (int i = 2; i < 78; i++) c = c ^ b[i];
      b.push_back(c);
      foreach (b[i]) begin
         if (second) exp2_q.push_back(b[i]);
         else exp_q.push_back(b[i]);
      end
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         hold_pending = 1'b0;
      end else begin
         if (tx_valid) any_valid = 1'b1;
         if (hold_pending) begin
            check("hold_valid", tx_valid, 1);
            check("hold_data", tx_data, hold_data);
         end
         hold_pending = tx_valid & ~tx_ready;
         hold_data    = tx_data;
         if (tx_valid && tx_ready) begin
            check("byte_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check($sformatf("byte%0d", n_bytes), tx_data, exp_q.pop_front());
            if (n_bytes == 0) first_cyc = cyc;
            last_cyc  = cyc;
            last_byte = tx_data;
            n_bytes++;
         end
         if (tx_valid2 && ready2) begin
            check("byte2_expected", exp2_q.size() > 0, 1);
            if (exp2_q.size() > 0) check($sformatf("s2_byte%0d", n_bytes2), tx_data2, exp2_q.pop_front());
            n_bytes2++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) tx_ready = ($urandom_range(0, 99) >= 30);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_inputs();
      for (int u = 0; u < 8; u++) x2sum_flat[u*64 +: 64] = m_x2[u];
      x2sumall  = m_all;
      looptimes = m_loop;
   endtask

   task automatic set_basic();
      for (int u = 0; u < 8; u++) m_x2[u] = 64'(u + 1);
      m_all  = 64'd36;
      m_loop = 32'h0000_0100;
   endtask

   task automatic rearm_pulse();
      rearm = 1'b1;
      tick(1);
      rearm = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int bound);
      int n;
      n = 0;
      while (!done && n < bound) begin
         tick(1);
         n++;
      end
      check(tag, done, 1);
   endtask

   initial begin
      #1_000_000;
      tests_failed++;
      $display("FAIL global_timeout: got running, want finished");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      rst = 1'b1; finish = 1'b0; finish2 = 1'b0; rearm = 1'b0;
      tx_ready = 1'b1; ready2 = 1'b1;
      for (int u = 0; u < 8; u++) m_x2[u] = 64'd0;
      m_all = 64'd0; m_loop = 32'd0;
      apply_inputs();
      tick(2);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pkt", pkt_count, 0);
      rst = 1'b0;
      tick(1);
      check("idle_busy", busy, 0);

      // basic packet with latency
      set_basic(); apply_inputs(); build_packet(0);
      n_bytes = 0;
      finish = 1'b1;
      tick(1);
      check("settle_busy", busy, 1);
      n = 1;
      while (!tx_valid && n < 50) begin
         tick(1);
         n++;
      end
      check("first_latency", n, S1 + 2);
      wait_done("basic_done", 200);
      check("basic_bytes", n_bytes, 79);
      check("basic_span", last_cyc - first_cyc, 78);
      check("basic_chk", last_byte, 8'h2D);
      check("basic_pkt", pkt_count, 1);
      check("basic_q", exp_q.size(), 0);
      check("basic_valid_off", tx_valid, 0);

      // finish toggled in DONE, and rearm with finish still high: no packet
      any_valid = 1'b0;
      finish = 1'b0; tick(3); finish = 1'b1; tick(20);
      check("ign_valid", any_valid, 0);
      check("ign_done", done, 1);
      check("ign_pkt", pkt_count, 1);
      rearm_pulse(); tick(15);
      check("rearm_done", done, 0);
      check("rearm_busy", busy, 0);
      check("rearm_valid", any_valid, 0);

      // backpressure, same data
      finish = 1'b0; tick(2);
      build_packet(0); n_bytes = 0;
      rand_ready = 1'b1;
      finish = 1'b1;
      wait_done("bp_done", 2000);
      rand_ready = 1'b0; tx_ready = 1'b1;
      check("bp_bytes", n_bytes, 79);
      check("bp_chk", last_byte, 8'h2D);
      check("bp_pkt", pkt_count, 2);
      check("bp_q", exp_q.size(), 0);

      // snapshot isolation
      rearm_pulse(); finish = 1'b0; tick(2);
      set_basic(); apply_inputs(); build_packet(0); n_bytes = 0;
      finish = 1'b1;
      n = 0;
      while (!tx_valid && n < 50) begin
         tick(1);
         n++;
      end
      x2sum_flat = '1; x2sumall = '1; looptimes = '1;
      wait_done("snap_done", 200);
      check("snap_chk", last_byte, 8'h2D);
      check("snap_pkt", pkt_count, 3);
      check("snap_q", exp_q.size(), 0);

      // settle timing: total arrives 7 cycles after the edge
      rearm_pulse(); finish = 1'b0; tick(2);
      set_basic(); m_all = 64'd0; apply_inputs(); build_packet(1);
      m_all = 64'd36; build_packet(0);
      n_bytes = 0; n_bytes2 = 0;
      finish = 1'b1; finish2 = 1'b1;
      tick(7);
      x2sumall = 64'd36;
      wait_done("settle_done", 200);
      check("settle_q", exp_q.size(), 0);
      check("settle_pkt", pkt_count, 4);
      check("s2_done", done2, 1);
      check("s2_q", exp2_q.size(), 0);
      check("s2_pkt", pkt_count2, 1);

      // abort in SETTLE
      rearm_pulse(); finish = 1'b0; finish2 = 1'b0; tick(2);
      any_valid = 1'b0;
      finish = 1'b1;
      tick(1);
      check("abort_settle", busy, 1);
      tick(2);
      finish = 1'b0;
      tick(1);
      check("abort_busy", busy, 0);
      tick(20);
      check("abort_valid", any_valid, 0);
      check("abort_done", done, 0);
      check("abort_pkt", pkt_count, 4);

      // random payloads under random backpressure
      for (int r = 0; r < 3; r++) begin
         for (int u = 0; u < 8; u++) m_x2[u] = {$urandom, $urandom};
         m_all = {$urandom, $urandom}; m_loop = $urandom;
         apply_inputs(); build_packet(0); n_bytes = 0;
         rand_ready = 1'b1;
         finish = 1'b1;
         wait_done("rnd_done", 2000);
         rand_ready = 1'b0; tx_ready = 1'b1;
         check("rnd_bytes", n_bytes, 79);
         check("rnd_q", exp_q.size(), 0);
         check("rnd_pkt", pkt_count, 16'(5 + r));
         rearm_pulse(); finish = 1'b0; tick(2);
      end

      // async reset at byte 40, finish held high through reset
      set_basic(); apply_inputs(); build_packet(0); n_bytes = 0;
      finish = 1'b1;
      n = 0;
      while (n_bytes < 40 && n < 200) begin
         @(posedge clk);
         #2;
         n++;
      end
      check("ar_reach", n_bytes, 40);
      rst = 1'b1;
      #1;
      check("ar_valid", tx_valid, 0);
      check("ar_busy", busy, 0);
      check("ar_done", done, 0);
      check("ar_pkt", pkt_count, 0);
      exp_q.delete();
      n_bytes = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      build_packet(0);
      wait_done("ar_done2", 200);
      check("ar_bytes", n_bytes, 79);
      check("ar_pkt2", pkt_count, 1);
      check("ar_q", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
